// File: rtl/multicycle_alu.sv
// Valid/ready ALU: single-cycle ADD/SUB/AND/OR/SLT plus an iterative shift-add MUL.
// Define ALU_DIV_EN to add a restoring unsigned DIV that shares the MUL iteration datapath.
module multicycle_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
`ifdef ALU_DIV_EN
    localparam logic [2:0] OP_DIV = 3'b111;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;

    // Iteration registers: MUL keeps {partial product, multiplier},
    // DIV keeps {partial remainder, dividend/quotient}; opnd_q is multiplicand or divisor.
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             start_busy;
    logic [WIDTH-1:0] sc_res_d;
    logic [WIDTH-1:0] sc_hi_d;
    logic             slt;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_d;
    logic [WIDTH-1:0] mul_lo_d;
    logic [WIDTH-1:0] step_hi_d;
    logic [WIDTH-1:0] step_lo_d;

`ifdef ALU_DIV_EN
    logic             is_div_q;
    logic             dbz_q;
    logic             sc_dbz_d;
    logic             start_div;
    logic [WIDTH:0]   div_r;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_hi_d;
    logic [WIDTH-1:0] div_lo_d;
`endif

    assign accept = in_valid && in_ready_q && (state_q == IDLE);
    assign slt    = $signed(a) < $signed(b);

`ifdef ALU_DIV_EN
    assign start_div  = (operation == OP_DIV) && (b != '0);
    assign start_busy = (operation == OP_MUL) || start_div;
`else
    assign start_busy = (operation == OP_MUL);
`endif

    // Results of the ops that complete in the accept cycle
    always_comb begin
        sc_res_d = '0;
        sc_hi_d  = '0;
`ifdef ALU_DIV_EN
        sc_dbz_d = 1'b0;
`endif
        case (operation)
            OP_NOP: sc_res_d = '0;
            OP_ADD: sc_res_d = a + b;
            OP_SUB: sc_res_d = a - b;
            OP_AND: sc_res_d = a & b;
            OP_OR:  sc_res_d = a | b;
            OP_SLT: sc_res_d = {{(WIDTH-1){1'b0}}, slt};
`ifdef ALU_DIV_EN
            OP_DIV: begin
                sc_res_d = '1;
                sc_hi_d  = a;
                sc_dbz_d = 1'b1;
            end
`endif
            default: sc_res_d = '0;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand, then shift the pair right
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_hi_d = mul_sum[WIDTH:1];
        mul_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

`ifdef ALU_DIV_EN
    // One restoring step; when div_ge the difference is below the divisor, so WIDTH bits suffice
    always_comb begin
        div_r    = {hi_q, lo_q[WIDTH-1]};
        div_ge   = div_r >= {1'b0, opnd_q};
        div_diff = div_r[WIDTH-1:0] - opnd_q;
        div_hi_d = div_ge ? div_diff : div_r[WIDTH-1:0];
        div_lo_d = {lo_q[WIDTH-2:0], div_ge};
    end

    assign step_hi_d = is_div_q ? div_hi_d : mul_hi_d;
    assign step_lo_d = is_div_q ? div_lo_d : mul_lo_d;
`else
    assign step_hi_d = mul_hi_d;
    assign step_lo_d = mul_lo_d;
`endif

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
`ifdef ALU_DIV_EN
            is_div_q    <= 1'b0;
            dbz_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (start_busy) begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_W'(WIDTH);
                            hi_q    <= '0;
`ifdef ALU_DIV_EN
                            is_div_q <= start_div;
                            lo_q     <= start_div ? a : b;
                            opnd_q   <= start_div ? b : a;
`else
                            lo_q     <= b;
                            opnd_q   <= a;
`endif
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= sc_res_d;
                            result_hi_q <= sc_hi_d;
                            zero_q      <= (sc_res_d == '0);
`ifdef ALU_DIV_EN
                            dbz_q       <= sc_dbz_d;
`endif
                        end
                    end
                end
                BUSY: begin
                    hi_q  <= step_hi_d;
                    lo_q  <= step_lo_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= step_lo_d;
                        result_hi_q <= step_hi_d;
                        zero_q      <= (step_lo_d == '0);
`ifdef ALU_DIV_EN
                        dbz_q       <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
`ifdef ALU_DIV_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (WIDTH=32); DIV cases follow ALU_DIV_EN.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  operation;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .operation  (operation),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_hi  (result_hi),
        .zero       (zero),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Waits for in_ready, presents one op for one edge, then counts edges until out_valid.
    task automatic run_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                          output int lat, output bit rdy_seen);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        operation = op; a = va; b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; operation = 3'b111;
        lat = 0; rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            rdy_seen |= in_ready;
            @(posedge clk); #1; lat++;
        end
        rdy_seen |= in_ready;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; operation = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 32'h0 ||
            result_hi !== 32'h0 || zero !== 1'b1 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: ov=%b ir=%b res=%h hi=%h z=%b dbz=%b, want 0 0 0 0 1 0",
                     out_valid, in_ready, result, result_hi, zero, div_by_zero);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ir=%b ov=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_cycle();
        logic [2:0]  t_op  [9] = '{3'b001, 3'b101, 3'b101, 3'b010, 3'b011, 3'b100, 3'b000, 3'b010, 3'b101};
        logic [31:0] t_a   [9] = '{32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd9, 32'h0000_F0F0,
                                   32'h0000_F0F0, 32'd5, 32'd0, 32'h8000_0000};
        logic [31:0] t_b   [9] = '{32'd7, 32'd1, 32'h8000_0000, 32'd9, 32'h0000_FF00,
                                   32'h0000_0F0F, 32'd6, 32'd1, 32'h7FFF_FFFF};
        logic [31:0] t_res [9] = '{32'd12, 32'd1, 32'd0, 32'd0, 32'h0000_F000,
                                   32'h0000_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd1};
        logic        t_z   [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int lat; bit rdy;
        for (int i = 0; i < 9; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], lat, rdy);
            vectors++;
            if (lat !== 0 || rdy !== 1'b0 || result !== t_res[i] || result_hi !== 32'h0 ||
                zero !== t_z[i] || div_by_zero !== 1'b0) begin
                miscompares++;
                $display("FAIL single[%0d] op=%b: lat=%0d rdy=%b res=%h hi=%h z=%b dbz=%b, want lat=0 rdy=0 res=%h hi=0 z=%b dbz=0",
                         i, t_op[i], lat, rdy, result, result_hi, zero, div_by_zero, t_res[i], t_z[i]);
            end
            consume();
        end
    endtask

    task automatic test_mul();
        logic [31:0] t_a  [3] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'd3};
        logic [31:0] t_b  [3] = '{32'd2, 32'h0001_0000, 32'd4};
        logic [31:0] t_lo [3] = '{32'hFFFF_FFFE, 32'h0, 32'd12};
        logic [31:0] t_hi [3] = '{32'd1, 32'd1, 32'd0};
        logic        t_z  [3] = '{1'b0, 1'b1, 1'b0};
        int lat; bit rdy;
        for (int i = 0; i < 3; i++) begin
            run_op(3'b110, t_a[i], t_b[i], lat, rdy);
            vectors++;
            if (lat !== 32 || rdy !== 1'b0 || result !== t_lo[i] || result_hi !== t_hi[i] ||
                zero !== t_z[i] || div_by_zero !== 1'b0) begin
                miscompares++;
                $display("FAIL mul[%0d]: lat=%0d rdy=%b res=%h hi=%h z=%b, want lat=32 rdy=0 res=%h hi=%h z=%b",
                         i, lat, rdy, result, result_hi, zero, t_lo[i], t_hi[i], t_z[i]);
            end
            consume();
        end
    endtask

    task automatic test_div();
        int lat; bit rdy;
`ifdef ALU_DIV_EN
        run_op(3'b111, 32'd100, 32'd7, lat, rdy);
        vectors++;
        if (lat !== 32 || rdy !== 1'b0 || result !== 32'd14 || result_hi !== 32'd2 ||
            zero !== 1'b0 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL div_100_7: lat=%0d res=%h hi=%h z=%b dbz=%b, want lat=32 res=e hi=2 z=0 dbz=0",
                     lat, result, result_hi, zero, div_by_zero);
        end
        consume();
        run_op(3'b111, 32'd5, 32'd0, lat, rdy);
        vectors++;
        if (lat !== 0 || result !== 32'hFFFF_FFFF || result_hi !== 32'd5 ||
            zero !== 1'b0 || div_by_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL div_by_zero: lat=%0d res=%h hi=%h z=%b dbz=%b, want lat=0 res=ffffffff hi=5 z=0 dbz=1",
                     lat, result, result_hi, zero, div_by_zero);
        end
        consume();
        run_op(3'b111, 32'd3, 32'd10, lat, rdy);
        vectors++;
        if (lat !== 32 || result !== 32'd0 || result_hi !== 32'd3 ||
            zero !== 1'b1 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL div_3_10: lat=%0d res=%h hi=%h z=%b dbz=%b, want lat=32 res=0 hi=3 z=1 dbz=0",
                     lat, result, result_hi, zero, div_by_zero);
        end
        consume();
`else
        run_op(3'b111, 32'd100, 32'd7, lat, rdy);
        vectors++;
        if (lat !== 0 || result !== 32'd0 || result_hi !== 32'd0 ||
            zero !== 1'b1 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL op111_nop: lat=%0d res=%h hi=%h z=%b dbz=%b, want lat=0 res=0 hi=0 z=1 dbz=0",
                     lat, result, result_hi, zero, div_by_zero);
        end
        consume();
`endif
    endtask

    task automatic test_hold();
        int lat; bit rdy;
        run_op(3'b001, 32'd1, 32'd1, lat, rdy);
        vectors++;
        if (lat !== 0 || result !== 32'd2) begin
            miscompares++;
            $display("FAIL hold_first: lat=%0d res=%h, want lat=0 res=2", lat, result);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd2 ||
                result_hi !== 32'd0 || zero !== 1'b0) begin
                miscompares++;
                $display("FAIL hold[%0d]: ov=%b ir=%b res=%h hi=%h z=%b, want 1 0 2 0 0",
                         i, out_valid, in_ready, result, result_hi, zero);
            end
        end
        consume();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: ov=%b ir=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midop();
        int lat; bit rdy;
        operation = 3'b110; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_reset: ov=%b ir=%b res=%h z=%b, want 0 0 0 1",
                     out_valid, in_ready, result, zero);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midop_stale[%0d]: ov=%b res=%h, want ov=0", i, out_valid, result);
            end
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_idle: ir=%b, want 1", in_ready);
        end
        run_op(3'b001, 32'd2, 32'd3, lat, rdy);
        vectors++;
        if (lat !== 0 || result !== 32'd5 || zero !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_next_add: lat=%0d res=%h z=%b, want lat=0 res=5 z=0", lat, result, zero);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat; bit rdy;
        run_op(3'b110, 32'd7, 32'd6, lat, rdy);
        vectors++;
        if (lat !== 32 || result !== 32'd42 || result_hi !== 32'd0) begin
            miscompares++;
            $display("FAIL b2b_mul: lat=%0d res=%h hi=%h, want lat=32 res=2a hi=0", lat, result, result_hi);
        end
        consume();
        run_op(3'b011, 32'hFFFF_0000, 32'h00FF_FF00, lat, rdy);
        vectors++;
        if (lat !== 0 || result !== 32'h00FF_0000 || result_hi !== 32'd0) begin
            miscompares++;
            $display("FAIL b2b_and: lat=%0d res=%h hi=%h, want lat=0 res=00ff0000 hi=0", lat, result, result_hi);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_div();
        test_hold();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
